// File: rtl/fx_reg_file_multiport.sv
// fx_reg_file_multiport: multi-port fixed-point GPR array plus byte-masked XER.
// Optional same-edge write-to-read forwarding is enabled by defining FXREG_WRITE_BYPASS_EN.
module fx_reg_file_multiport #(
    parameter int regSize           = 64,
    parameter int numGPRAddressBits = 6,
    parameter int numReadPorts      = 4,
    parameter int numWritePorts     = 4,
    parameter int fxRegFileInstance = 0
) (
    input  logic                                       clock_i,
    input  logic                                       reset_i,
    input  logic [0:numReadPorts-1]                    gprReadEn_i,
    input  logic [0:numReadPorts*numGPRAddressBits-1]  gprReadAddr_i,
    input  logic [0:numWritePorts-1]                   gprWriteEn_i,
    input  logic [0:numWritePorts*numGPRAddressBits-1] gprWriteAddr_i,
    input  logic [0:numWritePorts*regSize-1]           gprWriteVal_i,
    input  logic                                       XERWriteEn_i,
    input  logic [0:regSize/8-1]                       XERWriteMask_i,
    input  logic [0:regSize-1]                         XERVal_i,
    output logic [0:numReadPorts*regSize-1]            gprRead_o,
    output logic [0:numReadPorts-1]                    gprReadValid_o,
    output logic [0:regSize-1]                         XER_o,
    output logic                                       writeConflict_o,
    output logic [0:7]                                 conflictCount_o
);

    localparam int unsigned W     = regSize;
    localparam int unsigned AB    = numGPRAddressBits;
    localparam int unsigned NR    = numReadPorts;
    localparam int unsigned NW    = numWritePorts;
    localparam int unsigned DEPTH = 1 << numGPRAddressBits;
    localparam int unsigned LANES = regSize / 8;

    logic [W-1:0]  gpr     [DEPTH];
    logic [AB-1:0] rd_addr [NR];
    logic [AB-1:0] wr_addr [NW];
    logic [W-1:0]  wr_val  [NW];
    logic [W-1:0]  rd_next [NR];
    logic [0:NW-1] wr_win;
    logic          collision;
    logic [0:W-1]  xer_next;

    // The instance tag only labels debug output in simulation builds.
    logic unused_instance_tag;
    assign unused_instance_tag = (fxRegFileInstance != 0);

    always_comb begin
        for (int unsigned r = 0; r < NR; r++) begin
            rd_addr[r] = gprReadAddr_i[r*AB +: AB];
        end
        for (int unsigned p = 0; p < NW; p++) begin
            wr_addr[p] = gprWriteAddr_i[p*AB +: AB];
            wr_val[p]  = gprWriteVal_i[p*W +: W];
        end
    end

    // A port wins unless a higher-indexed enabled port targets the same address,
    // so at most one winner exists per address and any losing enabled port is a collision.
    always_comb begin
        for (int unsigned p = 0; p < NW; p++) begin
            wr_win[p] = gprWriteEn_i[p];
            for (int unsigned q = p + 1; q < NW; q++) begin
                if (gprWriteEn_i[q] && (wr_addr[q] == wr_addr[p])) begin
                    wr_win[p] = 1'b0;
                end
            end
        end
    end

    assign collision = |(gprWriteEn_i & ~wr_win);

    always_comb begin
        for (int unsigned r = 0; r < NR; r++) begin
            rd_next[r] = gpr[rd_addr[r]];
`ifdef FXREG_WRITE_BYPASS_EN
            for (int unsigned p = 0; p < NW; p++) begin
                if (wr_win[p] && (wr_addr[p] == rd_addr[r])) begin
                    rd_next[r] = wr_val[p];
                end
            end
`endif
        end
    end

    always_comb begin
        xer_next = XER_o;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (XERWriteMask_i[l]) begin
                xer_next[l*8 +: 8] = XERVal_i[l*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NW; p++) begin
                if (wr_win[p]) begin
                    gpr[wr_addr[p]] <= wr_val[p];
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            gprRead_o       <= '0;
            gprReadValid_o  <= '0;
            XER_o           <= '0;
            writeConflict_o <= 1'b0;
            conflictCount_o <= '0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) begin
                gprReadValid_o[r] <= gprReadEn_i[r];
                if (gprReadEn_i[r]) begin
                    gprRead_o[r*W +: W] <= rd_next[r];
                end
            end
            if (XERWriteEn_i) begin
                XER_o <= xer_next;
            end
            if (collision) begin
                writeConflict_o <= 1'b1;
                if (conflictCount_o != 8'hFF) begin
                    conflictCount_o <= conflictCount_o + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fx_reg_file_multiport.sv
// Directed bench for fx_reg_file_multiport (NR=NW=4, 64-bit, AB=6): a behavioural
// model is compared against every output on each falling edge, plus literal spot checks.
`timescale 1ns/1ps
module tb_fx_reg_file_multiport;

    localparam int W  = 64;
    localparam int AB = 6;
    localparam int NR = 4;
    localparam int NW = 4;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [0:NR-1]     rd_en;
    logic [0:NR*AB-1]  rd_addr;
    logic [0:NW-1]     wr_en;
    logic [0:NW*AB-1]  wr_addr;
    logic [0:NW*W-1]   wr_val;
    logic              xer_en;
    logic [0:7]        xer_mask;
    logic [0:63]       xer_val;
    logic [0:NR*W-1]   rd_data;
    logic [0:NR-1]     rd_valid;
    logic [0:63]       xer;
    logic              conflict;
    logic [0:7]        count;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [63:0] m_gpr [64];
    logic [63:0] m_rd  [NR];
    logic [0:NR-1] m_vld;
    logic [63:0] m_xer;
    bit          m_conf;
    int          m_cnt;

    fx_reg_file_multiport #(
        .regSize(W),
        .numGPRAddressBits(AB),
        .numReadPorts(NR),
        .numWritePorts(NW),
        .fxRegFileInstance(0)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .gprReadEn_i(rd_en),
        .gprReadAddr_i(rd_addr),
        .gprWriteEn_i(wr_en),
        .gprWriteAddr_i(wr_addr),
        .gprWriteVal_i(wr_val),
        .XERWriteEn_i(xer_en),
        .XERWriteMask_i(xer_mask),
        .XERVal_i(xer_val),
        .gprRead_o(rd_data),
        .gprReadValid_o(rd_valid),
        .XER_o(xer),
        .writeConflict_o(conflict),
        .conflictCount_o(count)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_port(input int r);
        return rd_data[r*W +: W];
    endfunction

    task automatic set_rd(input int r, input bit en, input int addr);
        rd_en[r] = en;
        rd_addr[r*AB +: AB] = AB'(addr);
    endtask

    task automatic set_wr(input int p, input bit en, input int addr, input logic [63:0] val);
        wr_en[p] = en;
        wr_addr[p*AB +: AB] = AB'(addr);
        wr_val[p*W +: W] = val;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NR; i++) set_rd(i, 1'b0, 0);
        for (int i = 0; i < NW; i++) set_wr(i, 1'b0, 0, 64'd0);
        xer_en = 1'b0;
        xer_mask = 8'h00;
        xer_val = 64'd0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 64; a++) m_gpr[a] = 64'd0;
        for (int r = 0; r < NR; r++) m_rd[r] = 64'd0;
        m_vld = '0;
        m_xer = 64'd0;
        m_conf = 1'b0;
        m_cnt = 0;
    endtask

    // One clock edge of architectural behaviour: reads see pre-edge contents
    // (or the winning same-edge write when forwarding is built in), then writes land.
    task automatic model_edge();
        int cnt [64];
        bit hit;
        int a;
        for (int r = 0; r < NR; r++) begin
            if (rd_en[r]) begin
                a = int'(rd_addr[r*AB +: AB]);
                m_rd[r] = m_gpr[a];
`ifdef FXREG_WRITE_BYPASS_EN
                hit = 1'b0;
                for (int p = NW - 1; p >= 0; p--) begin
                    if (!hit && wr_en[p] && int'(wr_addr[p*AB +: AB]) == a) begin
                        m_rd[r] = wr_val[p*W +: W];
                        hit = 1'b1;
                    end
                end
`endif
                m_vld[r] = 1'b1;
            end else begin
                m_vld[r] = 1'b0;
            end
        end
        for (int i = 0; i < 64; i++) cnt[i] = 0;
        for (int p = NW - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                a = int'(wr_addr[p*AB +: AB]);
                if (cnt[a] == 0) m_gpr[a] = wr_val[p*W +: W];
                cnt[a]++;
            end
        end
        hit = 1'b0;
        for (int i = 0; i < 64; i++) if (cnt[i] > 1) hit = 1'b1;
        if (hit) begin
            m_conf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (xer_en) begin
            for (int b = 0; b < 8; b++) begin
                if (xer_mask[b]) m_xer[63-8*b -: 8] = xer_val[8*b +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        if (!reset_i) model_reset();
        else model_edge();
        @(negedge clock_i);
    endtask

    always @(negedge clock_i) begin
        if (check_en) begin
            for (int r = 0; r < NR; r++) begin
                check($sformatf("cmp_rd%0d", r), rd_port(r), m_rd[r]);
            end
            check("cmp_valid", 64'(rd_valid), 64'(m_vld));
            check("cmp_xer", xer, m_xer);
            check("cmp_conflict", 64'(conflict), 64'(m_conf));
            check("cmp_count", 64'(count), 64'(m_cnt));
        end
    end

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        model_reset();
        #2 reset_i = 1'b0;
        check_en = 1'b1;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;

        // Reset state read back on all ports, then valid drops and data holds
        for (int r = 0; r < NR; r++) set_rd(r, 1'b1, r);
        tick();
        for (int r = 0; r < NR; r++) check($sformatf("t1_rd%0d", r), rd_port(r), 64'd0);
        check("t1_valid", 64'(rd_valid), 64'hF);
        idle_inputs();
        tick();
        check("t1_valid_drop", 64'(rd_valid), 64'h0);

        // Four parallel writes, idle, then four parallel reads
        for (int p = 0; p < NW; p++) set_wr(p, 1'b1, p, 64'(10 + p));
        tick();
        idle_inputs();
        tick();
        for (int r = 0; r < NR; r++) set_rd(r, 1'b1, r);
        tick();
        for (int r = 0; r < NR; r++) check($sformatf("t2_rd%0d", r), rd_port(r), 64'(10 + r));
        check("t2_valid", 64'(rd_valid), 64'hF);
        check("t2_conflict", 64'(conflict), 64'd0);
        idle_inputs();

        // Three-way collision on GPR5: port 3 must win
        set_wr(0, 1'b1, 5, 64'd20);
        set_wr(3, 1'b1, 5, 64'd21);
        set_wr(1, 1'b1, 5, 64'd22);
        tick();
        check("t3_conflict", 64'(conflict), 64'd1);
        check("t3_count1", 64'(count), 64'd1);
        idle_inputs();
        set_rd(0, 1'b1, 5);
        tick();
        check("t3_rd_gpr5", rd_port(0), 64'd21);
        idle_inputs();
        set_wr(0, 1'b1, 5, 64'd20);
        set_wr(3, 1'b1, 5, 64'd21);
        set_wr(1, 1'b1, 5, 64'd22);
        for (int i = 0; i < 300; i++) tick();
        check("t3_count_sat", 64'(count), 64'd255);
        idle_inputs();

        // Byte-masked XER: full write, edge lanes only, then an all-zero mask
        xer_en = 1'b1;
        xer_mask = 8'hFF;
        xer_val = 64'hA5FF00C3C300FFA5;
        tick();
        check("t4_xer_full", xer, 64'hA5FF00C3C300FFA5);
        xer_mask = 8'b1000_0001;
        xer_val = 64'h1111111111111111;
        tick();
        check("t4_xer_mask", xer, 64'h11FF00C3C300FF11);
        xer_mask = 8'h00;
        xer_val = 64'hFFFFFFFFFFFFFFFF;
        tick();
        check("t4_xer_nomask", xer, 64'h11FF00C3C300FF11);
        idle_inputs();

        // Same-edge write/read of GPR2, then a follow-up read
        set_wr(0, 1'b1, 2, 64'd30);
        set_rd(1, 1'b1, 2);
        tick();
`ifdef FXREG_WRITE_BYPASS_EN
        check("t5_same_edge", rd_port(1), 64'd30);
`else
        check("t5_same_edge", rd_port(1), 64'd12);
`endif
        idle_inputs();
        set_rd(1, 1'b1, 2);
        tick();
        check("t5_next_edge", rd_port(1), 64'd30);
        idle_inputs();

        // Colliding same-edge write seen by a read of GPR7, plus the top address
        set_wr(0, 1'b1, 7, 64'd40);
        set_wr(2, 1'b1, 7, 64'd41);
        set_wr(3, 1'b1, 63, 64'hFFFFFFFFFFFFFFFF);
        set_rd(3, 1'b1, 7);
        tick();
`ifdef FXREG_WRITE_BYPASS_EN
        check("t5_bypass_prio", rd_port(3), 64'd41);
`else
        check("t5_bypass_prio", rd_port(3), 64'd0);
`endif
        idle_inputs();
        set_rd(0, 1'b1, 63);
        set_rd(2, 1'b1, 7);
        tick();
        check("t5_gpr63", rd_port(0), 64'hFFFFFFFFFFFFFFFF);
        check("t5_gpr7", rd_port(2), 64'd41);
        check("t5_count_held", 64'(count), 64'd255);

        // Mixed traffic pattern, checked by the model every cycle
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < NW; p++)
                set_wr(p, ((i + p) % 3) != 0, (i * 3 + p * 5) % 16, 64'(i * 100 + p));
            for (int r = 0; r < NR; r++)
                set_rd(r, ((i + r) % 2) == 0, (i * 2 + r * 3) % 16);
            xer_en = (i % 4) == 0;
            xer_mask = 8'(i * 37);
            xer_val = {8{8'(i + 1)}};
            tick();
        end

        // Asynchronous reset mid-cycle, held across an edge with requests pending
        for (int p = 0; p < NW; p++) set_wr(p, 1'b1, p, 64'(50 + p));
        tick();
        #2 reset_i = 1'b0;
        model_reset();
        #1;
        check("t6_xer_clr", xer, 64'd0);
        check("t6_conflict_clr", 64'(conflict), 64'd0);
        check("t6_count_clr", 64'(count), 64'd0);
        check("t6_valid_clr", 64'(rd_valid), 64'd0);
        check("t6_rd0_clr", rd_port(0), 64'd0);
        for (int r = 0; r < NR; r++) set_rd(r, 1'b1, r);
        set_wr(0, 1'b1, 0, 64'd99);
        set_wr(1, 1'b1, 0, 64'd98);
        tick();
        reset_i = 1'b1;
        idle_inputs();
        for (int r = 0; r < NR; r++) set_rd(r, 1'b1, r);
        tick();
        for (int r = 0; r < NR; r++) check($sformatf("t6_rd%0d", r), rd_port(r), 64'd0);
        check("t6_conflict", 64'(conflict), 64'd0);
        idle_inputs();
        tick();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
